sram_macro_array: RTL and testbench
===================================

SRAM_MACRO_ARRAY -- requirements
Module: sram_macro_array

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits, a multiple of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 512, words, equal to 512*2^k with k>=0.
REQ-003 SHALL have derived localparams ADDR_W=clog2(DEPTH), NBYTE=DATA_W/8, NBANK=DEPTH/512.
REQ-004 SHALL have port clk, input, 1, clock; all macros clocked by clk.
REQ-005 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have ports req_valid (input, 1, request present) and req_ready (output, 1, request accepted this cycle when both are high).
REQ-007 SHALL have ports req_we (input, 1, 1=write, 0=read) and req_addr (input, ADDR_W, word address).
REQ-008 SHALL have ports req_wdata (input, DATA_W, write data) and req_be (input, NBYTE, byte enables, active-high).
REQ-009 SHALL have ports rsp_valid (output, 1, read data present), rsp_ready (input, 1, consumer accepts) and rsp_rdata (output, DATA_W, read data).

Function
REQ-010 SHALL tile NBANK x NBYTE instances of the 512x8 byte macro; bank = req_addr[ADDR_W-1:9], row = req_addr[8:0].
REQ-011 SHALL drive CEN (active-low) low only for the selected bank, and only in a cycle where a request is accepted; all other banks SHALL keep CEN high.
REQ-012 SHALL drive GWEN low only for an accepted write; for each byte lane, all 8 WEN bits SHALL equal ~req_be[lane].
REQ-013 SHALL treat a write with req_be=0 as accepted, with CEN low and no bit modified.
REQ-014 SHALL produce no response for writes; each accepted read SHALL produce exactly one response, in order.
REQ-015 SHALL assert rsp_valid on the cycle after read acceptance (latency 1), with SRAM_RDATA_REG_EN unset.
REQ-016 SHALL select rsp_rdata by the bank index registered at acceptance, never by the current req_addr.
REQ-017 SHALL capture read data into a hold register, so rsp_rdata and rsp_valid stay stable while rsp_valid=1 and rsp_ready=0, regardless of later macro activity.
REQ-018 SHALL compute req_ready = !reset and no pipeline stage holding data that cannot advance; with the default latency this is !rsp_valid || rsp_ready.
REQ-019 SHALL accept a new request in the same cycle a response is consumed, sustaining 1 read per cycle.
REQ-020 SHALL return the newly written data for a read to the same address accepted the cycle after a write (no stale data).
REQ-021 SHALL treat writes as always allowed when req_ready=1, including while a response is pending but being consumed.

Reset
REQ-022 SHALL hold req_ready=0 while reset=1, with every CEN high and GWEN high; requests presented during reset SHALL be ignored.
REQ-023 SHALL clear rsp_valid and all internal valid flags on reset; rsp_rdata SHALL reset to 0.
REQ-024 SHALL discard, with no response, any read in flight when reset asserts; memory contents SHALL not be initialised.
REQ-025 SHALL have req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, when macro SRAM_RDATA_REG_EN is defined, add one output register stage, making read latency 2 with throughput still 1 per cycle.
REQ-027 SHALL, in that configuration, deassert req_ready when the output stage is stalled and the intermediate stage is full.
REQ-028 SHALL, when SRAM_RDATA_REG_EN is undefined, have latency 1 and no extra stage.

Structure
REQ-029 SHALL place in a shared package sram_pkg: MACRO_ROWS=512, MACRO_BITS=8, and a function checking DEPTH legality.
REQ-030 SHALL contain one sub-module, sram_macro_bank (one bank: NBYTE byte macros sharing CEN/GWEN/A), instantiated NBANK times via generate.
REQ-031 SHALL fail at elaboration on illegal DATA_W or DEPTH.

Verification
REQ-032 Write 0xDEADBEEF at addr 5 with be=0xF, then read addr 5 -> rsp_valid one cycle later, rsp_rdata=0xDEADBEEF.
REQ-033 Write 0x11223344 at addr 7 with be=0xF, then 0xAABBCCDD with be=0x5, then read addr 7 -> rsp_rdata=0x11BB33DD.
REQ-034 DEPTH=1024, write 0xA5A5A5A5 at addr 3 and 0x5A5A5A5A at addr 515, read both back -> correct values returned, in request order.
REQ-035 Read stream at addrs 0..3 with rsp_ready held low for 3 cycles after the first response -> rdata stable, req_ready=0 during the stall, no response lost or duplicated.
REQ-036 Accept a read, assert reset the next cycle -> no rsp_valid during or after reset; req_ready=1 in the first post-reset cycle.
REQ-037 Rerun REQ-032 and REQ-035 with SRAM_RDATA_REG_EN defined -> latency 2 and identical data ordering.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and parameter-legality helpers for the tiled byte-macro SRAM array.
package sram_pkg;

  localparam int MACRO_ROWS   = 512;
  localparam int MACRO_BITS   = 8;
  localparam int MACRO_ADDR_W = 9;

  // Depth must be MACRO_ROWS times a power of two so bank decode is a plain slice.
  function automatic bit depth_legal(input int depth);
    int nbank;
    if (depth < MACRO_ROWS || (depth % MACRO_ROWS) != 0) return 1'b0;
    nbank = depth / MACRO_ROWS;
    return (nbank & (nbank - 1)) == 0;
  endfunction

  function automatic bit data_w_legal(input int data_w);
    return (data_w >= MACRO_BITS) && ((data_w % MACRO_BITS) == 0);
  endfunction

endpackage

// File: rtl/sram_macro_bank.sv
// One bank: NBYTE 512x8 byte macros sharing CEN/GWEN/A, each lane with its own bit-write mask.
module sram_macro_bank
  import sram_pkg::*;
#(
  parameter int NBYTE = 4
) (
  input  logic                          clk,
  input  logic                          cen,
  input  logic                          gwen,
  input  logic [MACRO_ADDR_W-1:0]       a,
  input  logic [NBYTE*MACRO_BITS-1:0]   d,
  input  logic [NBYTE*MACRO_BITS-1:0]   wen,
  output logic [NBYTE*MACRO_BITS-1:0]   q
);

  for (genvar lane = 0; lane < NBYTE; lane++) begin : g_lane
    logic [MACRO_BITS-1:0] mem [MACRO_ROWS];
    logic [MACRO_BITS-1:0] q_r;
    logic [MACRO_BITS-1:0] lane_d;
    logic [MACRO_BITS-1:0] lane_wen;

    assign lane_d   = d[lane*MACRO_BITS +: MACRO_BITS];
    assign lane_wen = wen[lane*MACRO_BITS +: MACRO_BITS];

    // Behavioural macro: a write leaves Q untouched, a read updates Q on the clock edge.
    always_ff @(posedge clk) begin
      if (!cen) begin
        if (!gwen) begin
          mem[a] <= (mem[a] & lane_wen) | (lane_d & ~lane_wen);
        end else begin
          q_r <= mem[a];
        end
      end
    end

    assign q[lane*MACRO_BITS +: MACRO_BITS] = q_r;
  end

endmodule

// File: rtl/sram_macro_array.sv
// Valid/ready SRAM built from NBANK x NBYTE byte macros; define SRAM_RDATA_REG_EN
// for an extra read-data register stage (latency 2, still one read per cycle).
module sram_macro_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [$clog2(DEPTH)-1:0]   req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W/8-1:0]        req_be,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NBYTE  = DATA_W / 8;
  localparam int NBANK  = DEPTH / MACRO_ROWS;
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

  if (!data_w_legal(DATA_W) || !depth_legal(DEPTH)) begin : g_param_check
    $error("sram_macro_array: illegal DATA_W or DEPTH");
  end

  logic [BANK_W-1:0]       req_bank;
  logic [MACRO_ADDR_W-1:0] req_row;
  logic                    accept;
  logic                    rd_accept;
  logic                    gwen;
  logic [DATA_W-1:0]       wen_bits;
  logic [DATA_W-1:0]       bank_q [NBANK];
  logic [BANK_W-1:0]       rd_bank_q;
  logic [DATA_W-1:0]       q_sel;

  assign req_row = req_addr[MACRO_ADDR_W-1:0];

  if (NBANK > 1) begin : g_bank_decode
    assign req_bank = req_addr[ADDR_W-1:MACRO_ADDR_W];
  end else begin : g_single_bank
    assign req_bank = '0;
  end

  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign gwen      = !(accept && req_we);

  for (genvar lane = 0; lane < NBYTE; lane++) begin : g_wen
    assign wen_bits[lane*MACRO_BITS +: MACRO_BITS] = {MACRO_BITS{~req_be[lane]}};
  end

  // Only the addressed bank is enabled, and only in a cycle that accepts a request.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic bank_cen;
    assign bank_cen = !(accept && (req_bank == BANK_W'(b)));

    sram_macro_bank #(
      .NBYTE (NBYTE)
    ) u_bank (
      .clk  (clk),
      .cen  (bank_cen),
      .gwen (gwen),
      .a    (req_row),
      .d    (req_wdata),
      .wen  (wen_bits),
      .q    (bank_q[b])
    );
  end

  // Read-data mux follows the bank captured at acceptance, not the live address.
  always_ff @(posedge clk) begin
    if (rd_accept) begin
      rd_bank_q <= req_bank;
    end
  end

  assign q_sel = bank_q[rd_bank_q];

`ifdef SRAM_RDATA_REG_EN

  logic              s1_valid_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              s2_free;
  logic              s1_move;

  assign s2_free   = !rsp_valid_q || rsp_ready;
  assign s1_move   = s1_valid_q && s2_free;
  assign req_ready = !reset && (!s1_valid_q || s2_free);
  assign rsp_valid = rsp_valid_q && !reset;
  assign rsp_rdata = rdata_q;

  // Stage 1 is the macro Q itself; it stays stable because nothing is accepted while it waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (rd_accept) begin
        s1_valid_q <= 1'b1;
      end else if (s1_move) begin
        s1_valid_q <= 1'b0;
      end
      if (s1_move) begin
        rsp_valid_q <= 1'b1;
        rdata_q     <= q_sel;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`else

  logic              rsp_valid_q;
  logic              from_hold_q;
  logic [DATA_W-1:0] hold_q;

  assign req_ready = !reset && (!rsp_valid_q || rsp_ready);
  assign rsp_valid = rsp_valid_q && !reset;
  assign rsp_rdata = (rsp_valid_q && !from_hold_q) ? q_sel : hold_q;

  // First response cycle shows the macro output directly; a stall parks it in hold_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      from_hold_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      if (rd_accept) begin
        rsp_valid_q <= 1'b1;
        from_hold_q <= 1'b0;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      if (rsp_valid_q && !from_hold_q && !rsp_ready) begin
        hold_q      <= q_sel;
        from_hold_q <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_sram_macro_array.sv
// Directed bench for sram_macro_array (DEPTH=1024, two banks); adapts to SRAM_RDATA_REG_EN latency.
module tb_sram_macro_array;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int NBYTE  = 4;
`ifdef SRAM_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [NBYTE-1:0]  req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] streamExp [4] = '{32'h0000_1111, 32'h2222_0000, 32'h3333_4444, 32'h5555_6666};

  sram_macro_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input logic [NBYTE-1:0] be);
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic writeWord(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input string tag);
    applyStimulus(1'b1, 1'b1, addr, data, be);
    #1;
    checkOutput({tag, " wr ready"}, 32'(req_ready), 32'd1);
    step();
    idle();
    checkOutput({tag, " wr no rsp"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic readWord(input logic [ADDR_W-1:0] addr, input logic [31:0] expData, input string tag);
    applyStimulus(1'b1, 1'b0, addr, '0, '0);
    #1;
    checkOutput({tag, " rd ready"}, 32'(req_ready), 32'd1);
    step();
    idle();
    for (int i = 1; i < LAT; i++) begin
      checkOutput({tag, " early"}, 32'(rsp_valid), 32'd0);
      step();
    end
    checkOutput({tag, " valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, " data"}, rsp_rdata, expData);
    step();
    checkOutput({tag, " drained"}, 32'(rsp_valid), 32'd0);
  endtask

  // Reads 0..3 back to back; the consumer stalls 3 cycles on the first response.
  task automatic streamTest(input string tag);
    int sent = 0;
    int got = 0;
    int stallLeft = 0;
    bit stallStarted = 1'b0;
    bit accepted;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (sent < 4) applyStimulus(1'b1, 1'b0, ADDR_W'(sent), '0, '0);
      else idle();
      if (rsp_valid && !stallStarted) begin
        stallStarted = 1'b1;
        stallLeft    = 3;
      end
      rsp_ready = (stallLeft == 0);
      #1;
      accepted = req_valid && req_ready;
      if (rsp_valid) begin
        checkOutput($sformatf("%s rdata %0d", tag, got), rsp_rdata, streamExp[got]);
        if (!rsp_ready) begin
          checkOutput({tag, " stall ready"}, 32'(req_ready), 32'd0);
          stallLeft--;
        end else begin
          got++;
        end
      end
      step();
      if (accepted) sent++;
    end
    rsp_ready = 1'b1;
    idle();
    checkOutput({tag, " count"}, 32'(got), 32'd4);
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, " no dup"}, 32'(rsp_valid), 32'd0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 10'd0, '0, '0);
    step();
    step();
    checkOutput("reset ready", 32'(req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rdata", rsp_rdata, 32'd0);

    reset = 1'b0;
    idle();
    #1;
    checkOutput("post-reset ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("ignored rd in reset", 32'(rsp_valid), 32'd0);
    end

    writeWord(10'd5, 32'hDEADBEEF, 4'hF, "w5");
    readWord(10'd5, 32'hDEADBEEF, "r5");

    writeWord(10'd7, 32'h11223344, 4'hF, "w7a");
    writeWord(10'd7, 32'hAABBCCDD, 4'h5, "w7b");
    readWord(10'd7, 32'h11BB33DD, "r7 be");
    writeWord(10'd7, 32'hFFFFFFFF, 4'h0, "w7 be0");
    readWord(10'd7, 32'h11BB33DD, "r7 be0");

    writeWord(10'd3, 32'hA5A5A5A5, 4'hF, "w3");
    writeWord(10'd515, 32'h5A5A5A5A, 4'hF, "w515");
    applyStimulus(1'b1, 1'b0, 10'd3, '0, '0);
    step();
    applyStimulus(1'b1, 1'b0, 10'd515, '0, '0);
    #1;
    checkOutput("bank b2b ready", 32'(req_ready), 32'd1);
    if (LAT == 1) begin
      checkOutput("bank rsp0 valid", 32'(rsp_valid), 32'd1);
      checkOutput("bank rsp0 data", rsp_rdata, 32'hA5A5A5A5);
    end
    step();
    idle();
    if (LAT == 2) begin
      checkOutput("bank rsp0 valid", 32'(rsp_valid), 32'd1);
      checkOutput("bank rsp0 data", rsp_rdata, 32'hA5A5A5A5);
      step();
    end
    checkOutput("bank rsp1 valid", 32'(rsp_valid), 32'd1);
    checkOutput("bank rsp1 data", rsp_rdata, 32'h5A5A5A5A);
    step();
    checkOutput("bank drained", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 4; i++) writeWord(ADDR_W'(i), streamExp[i], 4'hF, "wstream");
    streamTest("stream");

    applyStimulus(1'b1, 1'b0, 10'd5, '0, '0);
    step();
    reset = 1'b1;
    idle();
    #1;
    checkOutput("inflight rst valid", 32'(rsp_valid), 32'd0);
    checkOutput("inflight rst ready", 32'(req_ready), 32'd0);
    step();
    checkOutput("inflight rst valid2", 32'(rsp_valid), 32'd0);
    checkOutput("inflight rst rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("inflight post ready", 32'(req_ready), 32'd1);
    checkOutput("inflight post valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("inflight discarded", 32'(rsp_valid), 32'd0);
    end

    readWord(10'd5, 32'hDEADBEEF, "r5 after rst");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
